// File: rtl/fir_stream_sink.sv
// Stream sink for the FIR output: captures valid samples into a FIFO, keeps a
// saturating sample count and rotating XOR checksum, and flags end of run.
module fir_stream_sink #(
    parameter int DATA_W    = 30,
    parameter int DEPTH     = 16,
    parameter int N_SAMPLES = 1024
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_vin,
    input  logic signed [DATA_W-1:0]             i_din,
    input  logic                                 i_rd_en,
    output logic signed [DATA_W-1:0]             o_rd_data,
    output logic                                 o_rd_valid,
    output logic                                 o_empty,
    output logic                                 o_full,
    output logic                                 o_ovf,
    output logic                                 o_extra,
    output logic [$clog2(N_SAMPLES+1)-1:0]       o_count,
    output logic [DATA_W-1:0]                    o_checksum,
    output logic                                 o_end_sim
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(N_SAMPLES);

    typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [DATA_W-1:0]  r_mem [DEPTH];
    logic [AW:0]               r_wptr;
    logic [AW:0]               r_rptr;
    logic [AW:0]               w_wptr_nxt;
    logic [AW:0]               w_rptr_nxt;
    logic                      r_empty;
    logic                      r_full;
    logic                      r_ovf;
    logic                      r_extra;
    logic [CNT_W-1:0]          r_count;
    logic [DATA_W-1:0]         r_checksum;
    logic signed [DATA_W-1:0]  r_rd_data;
    logic                      r_rd_valid;
    logic                      w_accept;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;

    function automatic logic [DATA_W-1:0] rotl1_xor(input logic [DATA_W-1:0] c,
                                                    input logic [DATA_W-1:0] d);
        return {c[DATA_W-2:0], c[DATA_W-1]} ^ d;
    endfunction

    // A full FIFO still takes a sample when a pop frees the slot the same edge.
    assign w_accept   = (r_state == COLLECT) && i_vin;
    assign w_pop      = i_rd_en && !r_empty;
    assign w_push     = w_accept && (!r_full || w_pop);
    assign w_drop     = w_accept && r_full && !w_pop;
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_accept && (r_count == LAST_CNT)) w_state_nxt = DRAIN;
            DRAIN:   if (r_empty) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= COLLECT;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_extra    <= 1'b0;
            r_count    <= '0;
            r_checksum <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_empty    <= (w_wptr_nxt == w_rptr_nxt);
            r_full     <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                          (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_data <= r_mem[r_rptr[AW-1:0]];
            // Dropped samples are still counted and folded into the checksum.
            if (w_accept) begin
                if (r_count != MAX_CNT) r_count <= r_count + CNT_W'(1);
                r_checksum <= rotl1_xor(r_checksum, i_din);
            end
            if (w_drop) r_ovf <= 1'b1;
            if (i_vin && (r_state != COLLECT)) r_extra <= 1'b1;
        end
    end

    // Contents need no reset: the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_ovf      = r_ovf;
    assign o_extra    = r_extra;
    assign o_count    = r_count;
    assign o_checksum = r_checksum;
    assign o_end_sim  = (r_state == DONE);

endmodule

// File: tb/tb_fir_stream_sink.sv
// Bench for fir_stream_sink: directed scenarios plus random traffic, checked
// against a queue-based reference model and a pop scoreboard.
module tb_fir_stream_sink;

    localparam int DW  = 30;
    localparam int DEP = 4;
    localparam int NS  = 12;
    localparam int CW  = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_valid;
    logic          o_empty;
    logic          o_full;
    logic          o_ovf;
    logic          o_extra;
    logic [CW-1:0] o_count;
    logic [DW-1:0] o_checksum;
    logic          o_end_sim;

    always #5 clk = ~clk;

    fir_stream_sink #(.DATA_W(DW), .DEPTH(DEP), .N_SAMPLES(NS)) dut (
        .i_clk(clk), .i_rst(rst), .i_vin(vin), .i_din(din), .i_rd_en(rd_en),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_empty(o_empty),
        .o_full(o_full), .o_ovf(o_ovf), .o_extra(o_extra), .o_count(o_count),
        .o_checksum(o_checksum), .o_end_sim(o_end_sim)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain queue FIFO and run phase (0 collect, 1 drain, 2 done)
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] sb_q[$];
    int            m_phase = 0;
    int            m_cnt = 0;
    logic [DW-1:0] m_cks = '0;
    logic [DW-1:0] m_rd_data = '0;
    bit            m_rdv = 0;
    bit            m_ovf = 0;
    bit            m_extra = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] c);
        logic [2*DW-1:0] t;
        t = {c, c};
        return t[2*DW-2 -: DW];
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [DW-1:0] d, input bit re);
        int pre_phase;
        int pre_size;
        if (r) begin
            m_q.delete();
            m_phase = 0; m_cnt = 0; m_cks = '0; m_rd_data = '0;
            m_rdv = 0; m_ovf = 0; m_extra = 0;
            return;
        end
        pre_phase = m_phase;
        pre_size  = m_q.size();
        m_rdv = re && (pre_size > 0);
        if (m_rdv) begin
            m_rd_data = m_q.pop_front();
            sb_q.push_back(m_rd_data);
        end
        if (v && pre_phase == 0) begin
            m_cnt++;
            m_cks = rotl(m_cks) ^ d;
            if (m_q.size() < DEP) m_q.push_back(d);
            else m_ovf = 1;
            if (m_cnt == NS) m_phase = 1;
        end else if (v) begin
            m_extra = 1;
        end
        if (pre_phase == 1 && pre_size == 0) m_phase = 2;
    endtask

    task automatic check_all();
        chk("empty",    64'(o_empty),    64'(m_q.size() == 0));
        chk("full",     64'(o_full),     64'(m_q.size() == DEP));
        chk("ovf",      64'(o_ovf),      64'(m_ovf));
        chk("extra",    64'(o_extra),    64'(m_extra));
        chk("count",    64'(o_count),    64'(m_cnt));
        chk("checksum", 64'(o_checksum), 64'(m_cks));
        chk("end_sim",  64'(o_end_sim),  64'(m_phase == 2));
        chk("rd_valid", 64'(o_rd_valid), 64'(m_rdv));
        chk("rd_data",  64'(o_rd_data),  64'(m_rd_data));
    endtask

    task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit re);
        @(negedge clk);
        rst = r; vin = v; din = d; rd_en = re;
        model_edge(r, v, d, re);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom());
    endfunction

    // Scoreboard monitor: every RD_VALID pulse must match the oldest expected pop
    always @(negedge clk) begin
        if (o_rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_pop: got rd_valid=1 data=0x%0h, expected no pop", o_rd_data);
            end else begin
                logic [DW-1:0] e;
                e = sb_q.pop_front();
                chk("sb_order", 64'(o_rd_data), 64'(e));
            end
        end
    end

    initial begin
        step(1, 0, '0, 0);

        // Overflow: six pushes into a 4-deep FIFO, then drain and pop on empty
        for (int i = 0; i < 6; i++) step(0, 1, DW'(10 + i), 0);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1);

        // Full with simultaneous push and pop
        step(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, rnd(), 0);
        step(0, 1, DW'(77), 1);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1);

        // Pointer wrap, then end of run, extra sample and empty pop
        step(1, 0, '0, 0);
        for (int i = 0; i < 11; i++) begin
            step(0, 1, rnd(), 0);
            step(0, 0, '0, 1);
        end
        step(0, 1, rnd(), 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        step(0, 1, rnd(), 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Reset while draining with three entries queued
        step(1, 0, '0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, rnd(), 1);
        step(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, rnd(), 0);
        step(1, 1, rnd(), 1);
        step(0, 0, '0, 0);

        // Random traffic with varying pop pressure
        for (int run = 0; run < 6; run++) begin
            step(1, 0, '0, 0);
            for (int cyc = 0; cyc < 150; cyc++) begin
                step(0, $urandom_range(0, 99) < 60, rnd(),
                     $urandom_range(0, 99) < (20 + 15 * run));
            end
        end

        step(0, 0, '0, 0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
